// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared widths and ALU opcode encodings for the datapath
// Optional multiply/divide is enabled by defining DATAPATH_MULDIV_EN.
package datapath_pkg;

   localparam int DATA_W = 32;
   localparam int OPC_W  = 5;

   typedef enum logic [OPC_W-1:0] {
      OP_INC  = 5'b00000,
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_SHR  = 5'b00101,
      OP_SHRA = 5'b00110,
      OP_SHL  = 5'b00111,
      OP_ROR  = 5'b01000,
      OP_ROL  = 5'b01001,
      OP_AND  = 5'b01010,
      OP_OR   = 5'b01011,
      OP_MUL  = 5'b01111,
      OP_DIV  = 5'b10000,
      OP_NEG  = 5'b10001,
      OP_NOT  = 5'b10010
   } opcode_e;

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU, A from Y and B from the bus, 64-bit {hi,lo} result
// MUL/DIV exist only when DATAPATH_MULDIV_EN is defined; otherwise those opcodes yield 0.
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [OPC_W-1:0]    opcode,
   output logic [2*DATA_W-1:0] result
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0]   sh;
   logic [SH_W-1:0]   sh_inv;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   // Rotates use the complementary amount mod DATA_W, so a zero rotate returns A unchanged.
   assign sh     = b[SH_W-1:0];
   assign sh_inv = -sh;

`ifdef DATAPATH_MULDIV_EN
   logic signed [2*DATA_W-1:0] a_ext;
   logic signed [2*DATA_W-1:0] b_ext;
   logic signed [2*DATA_W-1:0] product;
   logic signed [DATA_W-1:0]   quot;
   logic signed [DATA_W-1:0]   rem;

   assign a_ext   = {{DATA_W{a[DATA_W-1]}}, a};
   assign b_ext   = {{DATA_W{b[DATA_W-1]}}, b};
   assign product = a_ext * b_ext;
   // Division by zero is defined as quotient = remainder = 0.
   assign quot    = (b == '0) ? '0 : $signed(a) / $signed(b);
   assign rem     = (b == '0) ? '0 : $signed(a) % $signed(b);
`endif

   always_comb begin
      hi = '0;
      lo = '0;
      case (opcode)
         OP_INC:  lo = b + DATA_W'(1);
         OP_ADD:  lo = a + b;
         OP_SUB:  lo = a - b;
         OP_AND:  lo = a & b;
         OP_OR:   lo = a | b;
         OP_SHR:  lo = a >> sh;
         OP_SHRA: lo = $signed(a) >>> sh;
         OP_SHL:  lo = a << sh;
         OP_ROR:  lo = (a >> sh) | (a << sh_inv);
         OP_ROL:  lo = (a << sh) | (a >> sh_inv);
`ifdef DATAPATH_MULDIV_EN
         OP_MUL:  {hi, lo} = product;
         OP_DIV: begin
            lo = quot;
            hi = rem;
         end
`endif
         OP_NEG:  lo = -b;
         OP_NOT:  lo = ~b;
         default: begin
            hi = '0;
            lo = '0;
         end
      endcase
   end

   assign result = {hi, lo};

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - Mini-SRC style register file, shared bus and ALU with externally driven controls
// Build option DATAPATH_MULDIV_EN adds signed MUL/DIV to the ALU.
module datapath
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              R0_in,
   input  logic              R1_in,
   input  logic              PC_in,
   input  logic              IR_in,
   input  logic              MAR_in,
   input  logic              Y_in,
   input  logic              MDR_in,
   input  logic              Read,
   input  logic              Z_in,
   input  logic              R0_out,
   input  logic              R1_out,
   input  logic              PC_out,
   input  logic              MDR_out,
   input  logic              Zlow_out,
   input  logic [OPC_W-1:0]  alu_instruction,
   input  logic [DATA_W-1:0] Mdatain,
   output logic [DATA_W-1:0] Bus_Data,
   output logic [DATA_W-1:0] R0_Data,
   output logic [DATA_W-1:0] R1_Data,
   output logic [DATA_W-1:0] PC_Data,
   output logic [DATA_W-1:0] IR_Data,
   output logic [DATA_W-1:0] MAR_Data,
   output logic [DATA_W-1:0] MDR_Data,
   output logic [DATA_W-1:0] Y_Data,
   output logic [DATA_W-1:0] Zhigh_Data,
   output logic [DATA_W-1:0] Zlow_Data
);

   logic [DATA_W-1:0]   r0_q, r1_q, pc_q, ir_q, mar_q, mdr_q, y_q, zhigh_q, zlow_q;
   logic [DATA_W-1:0]   bus;
   logic [2*DATA_W-1:0] alu_result;

   // Fixed priority replaces tri-state contention: the first asserted source wins.
   always_comb begin
      bus = '0;
      if (MDR_out)
         bus = mdr_q;
      else if (Zlow_out)
         bus = zlow_q;
      else if (PC_out)
         bus = pc_q;
      else if (R1_out)
         bus = r1_q;
      else if (R0_out)
         bus = r0_q;
   end

   datapath_alu u_alu (
      .a      (y_q),
      .b      (bus),
      .opcode (alu_instruction),
      .result (alu_result)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         r0_q    <= '0;
         r1_q    <= '0;
         pc_q    <= '0;
         ir_q    <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         y_q     <= '0;
         zhigh_q <= '0;
         zlow_q  <= '0;
      end else begin
         if (R0_in)  r0_q  <= bus;
         if (R1_in)  r1_q  <= bus;
         if (PC_in)  pc_q  <= bus;
         if (IR_in)  ir_q  <= bus;
         if (MAR_in) mar_q <= bus;
         if (Y_in)   y_q   <= bus;
         if (MDR_in) mdr_q <= Read ? Mdatain : bus;
         if (Z_in) begin
            zhigh_q <= alu_result[2*DATA_W-1:DATA_W];
            zlow_q  <= alu_result[DATA_W-1:0];
         end
      end
   end

   assign Bus_Data   = bus;
   assign R0_Data    = r0_q;
   assign R1_Data    = r1_q;
   assign PC_Data    = pc_q;
   assign IR_Data    = ir_q;
   assign MAR_Data   = mar_q;
   assign MDR_Data   = mdr_q;
   assign Y_Data     = y_q;
   assign Zhigh_Data = zhigh_q;
   assign Zlow_Data  = zlow_q;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed scoreboard bench for datapath (MUL/DIV expectations follow DATAPATH_MULDIV_EN)
module tb_datapath;

   localparam int S_BUS = 0, S_R0 = 1, S_R1 = 2, S_PC = 3, S_IR = 4, S_MAR = 5;
   localparam int S_MDR = 6, S_Y = 7, S_ZH = 8, S_ZL = 9;

   logic        clk, clr;
   logic        R0_in, R1_in, PC_in, IR_in, MAR_in, Y_in, MDR_in, Read, Z_in;
   logic        R0_out, R1_out, PC_out, MDR_out, Zlow_out;
   logic [4:0]  alu_instruction;
   logic [31:0] Mdatain;
   logic [31:0] Bus_Data, R0_Data, R1_Data, PC_Data, IR_Data, MAR_Data, MDR_Data, Y_Data;
   logic [31:0] Zhigh_Data, Zlow_Data;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   datapath dut (
      .clk(clk), .clr(clr),
      .R0_in(R0_in), .R1_in(R1_in), .PC_in(PC_in), .IR_in(IR_in), .MAR_in(MAR_in),
      .Y_in(Y_in), .MDR_in(MDR_in), .Read(Read), .Z_in(Z_in),
      .R0_out(R0_out), .R1_out(R1_out), .PC_out(PC_out), .MDR_out(MDR_out), .Zlow_out(Zlow_out),
      .alu_instruction(alu_instruction), .Mdatain(Mdatain),
      .Bus_Data(Bus_Data), .R0_Data(R0_Data), .R1_Data(R1_Data), .PC_Data(PC_Data),
      .IR_Data(IR_Data), .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .Y_Data(Y_Data),
      .Zhigh_Data(Zhigh_Data), .Zlow_Data(Zlow_Data)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] observe(input int sig);
      case (sig)
         S_BUS:   return Bus_Data;
         S_R0:    return R0_Data;
         S_R1:    return R1_Data;
         S_PC:    return PC_Data;
         S_IR:    return IR_Data;
         S_MAR:   return MAR_Data;
         S_MDR:   return MDR_Data;
         S_Y:     return Y_Data;
         S_ZH:    return Zhigh_Data;
         default: return Zlow_Data;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sig, input logic [31:0] v);
      sb_t e;
      e.tag = tag;
      e.sig = sig;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      sb_t         e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.sig);
         n_tests++;
         assert (o === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
         end
      end
   endtask

   task automatic idle();
      {R0_in, R1_in, PC_in, IR_in, MAR_in, Y_in, MDR_in, Read, Z_in} = '0;
      {R0_out, R1_out, PC_out, MDR_out, Zlow_out} = '0;
      alu_instruction = 5'b00000;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_mdr(input logic [31:0] v);
      idle();
      Read = 1'b1;
      MDR_in = 1'b1;
      Mdatain = v;
      tick();
      idle();
   endtask

   task automatic set_y(input logic [31:0] v);
      load_mdr(v);
      MDR_out = 1'b1;
      Y_in = 1'b1;
      tick();
      idle();
   endtask

   task automatic run_alu(input string tag, input logic [4:0] op, input logic [31:0] bval,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      load_mdr(bval);
      MDR_out = 1'b1;
      Z_in = 1'b1;
      alu_instruction = op;
      expect_val({tag, "_hi"}, S_ZH, exp_hi);
      expect_val({tag, "_lo"}, S_ZL, exp_lo);
      tick();
      idle();
      drain();
   endtask

   initial begin
      logic [31:0] ir_val;
      clk = 1'b0;
      Mdatain = '0;
      idle();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;

      // Preload R0, then clear with a competing load asserted.
      load_mdr(32'h0000_1234);
      MDR_out = 1'b1; R0_in = 1'b1;
      expect_val("r0_preload", S_R0, 32'h0000_1234);
      tick(); idle(); drain();
      clr = 1'b1; MDR_out = 1'b1; R0_in = 1'b1; Y_in = 1'b1;
      tick();
      clr = 1'b0; idle(); #1;
      expect_val("rst_r0", S_R0, '0);   expect_val("rst_r1", S_R1, '0);
      expect_val("rst_pc", S_PC, '0);   expect_val("rst_ir", S_IR, '0);
      expect_val("rst_mar", S_MAR, '0); expect_val("rst_mdr", S_MDR, '0);
      expect_val("rst_y", S_Y, '0);     expect_val("rst_zh", S_ZH, '0);
      expect_val("rst_zl", S_ZL, '0);   expect_val("rst_bus", S_BUS, '0);
      drain();

      // NOT sequence
      load_mdr(32'h0000_1234);
      MDR_out = 1'b1; R0_in = 1'b1;
      expect_val("not_r0", S_R0, 32'h0000_1234);
      tick(); idle(); drain();
      load_mdr(32'hF0F0_F0F0);
      MDR_out = 1'b1; R1_in = 1'b1;
      expect_val("not_r1", S_R1, 32'hF0F0_F0F0);
      tick(); idle(); drain();
      PC_out = 1'b1; MAR_in = 1'b1; Z_in = 1'b1; alu_instruction = 5'b00000;
      expect_val("inc_mar", S_MAR, 32'h0);
      expect_val("inc_zl", S_ZL, 32'h1);
      expect_val("inc_zh", S_ZH, 32'h0);
      tick(); idle(); drain();
      Zlow_out = 1'b1; PC_in = 1'b1;
      expect_val("pc_inc", S_PC, 32'h1);
      tick(); idle(); drain();
      ir_val = 32'h9008_0000;
      load_mdr(ir_val);
      MDR_out = 1'b1; IR_in = 1'b1;
      expect_val("ir_load", S_IR, ir_val);
      tick(); idle(); drain();
      R1_out = 1'b1; Z_in = 1'b1; alu_instruction = ir_val[31:27];
      expect_val("not_zl", S_ZL, 32'h0F0F_0F0F);
      tick(); idle(); drain();
      Zlow_out = 1'b1; R0_in = 1'b1;
      expect_val("not_r0_wb", S_R0, 32'h0F0F_0F0F);
      tick(); idle(); drain();

      // MDR loads from the bus when Read is low
      PC_out = 1'b1; MDR_in = 1'b1; Read = 1'b0; Mdatain = 32'hDEAD_BEEF;
      expect_val("mdr_from_bus", S_MDR, 32'h1);
      tick(); idle(); drain();

      // Arithmetic and logic
      set_y(32'h7FFF_FFFF);
      run_alu("add_wrap", 5'b00011, 32'h1, 32'h0, 32'h8000_0000);
      set_y(32'h0);
      run_alu("sub_wrap", 5'b00100, 32'h1, 32'h0, 32'hFFFF_FFFF);
      set_y(32'hFF00_FF00);
      run_alu("and", 5'b01010, 32'h0FF0_0FF0, 32'h0, 32'h0F00_0F00);
      run_alu("or", 5'b01011, 32'h0FF0_0FF0, 32'h0, 32'hFFF0_FFF0);
      run_alu("neg", 5'b10001, 32'h1, 32'h0, 32'hFFFF_FFFF);
      run_alu("bad_op", 5'b11111, 32'h5, 32'h0, 32'h0);

      // Shifts and rotates, including an amount that only uses B[4:0]
      set_y(32'h8000_0001);
      run_alu("shr", 5'b00101, 32'h4, 32'h0, 32'h0800_0000);
      run_alu("shl_b36", 5'b00111, 32'h24, 32'h0, 32'h0000_0010);
      run_alu("ror", 5'b01000, 32'h4, 32'h0, 32'h1800_0000);
      run_alu("rol", 5'b01001, 32'h4, 32'h0, 32'h0000_0018);
      run_alu("ror_zero", 5'b01000, 32'h0, 32'h0, 32'h8000_0001);
      set_y(32'h8000_0000);
      run_alu("shra", 5'b00110, 32'h4, 32'h0, 32'hF800_0000);

      // Signed multiply and divide
      set_y(32'hFFFF_FFFE);
`ifdef DATAPATH_MULDIV_EN
      run_alu("mul", 5'b01111, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
`else
      run_alu("mul_off", 5'b01111, 32'h3, 32'h0, 32'h0);
`endif
      set_y(32'hFFFF_FFF9);
`ifdef DATAPATH_MULDIV_EN
      run_alu("div", 5'b10000, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
      run_alu("div_off", 5'b10000, 32'h2, 32'h0, 32'h0);
`endif
      run_alu("div_zero", 5'b10000, 32'h0, 32'h0, 32'h0);

      // Bus priority
      load_mdr(32'h5);
      MDR_out = 1'b1; R0_in = 1'b1;
      tick(); idle();
      load_mdr(32'h9);
      R0_out = 1'b1; MDR_out = 1'b1; #1;
      expect_val("prio_mdr_r0", S_BUS, 32'h9);
      drain();
      MDR_out = 1'b0; #1;
      expect_val("r0_alone", S_BUS, 32'h5);
      drain();
      R1_out = 1'b1; #1;
      expect_val("prio_r1_r0", S_BUS, 32'hF0F0_F0F0);
      drain();
      idle(); #1;
      expect_val("bus_idle", S_BUS, 32'h0);
      drain();

      // Clear mid-sequence overrides a simultaneous load
      R1_out = 1'b1; R0_in = 1'b1; clr = 1'b1;
      expect_val("clr_over_load", S_R0, 32'h0);
      expect_val("clr_r1", S_R1, 32'h0);
      tick(); clr = 1'b0; idle(); drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
